// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared state encoding and constants for the instruction fetch memory
package instr_mem_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam int WORD_BYTES = 4;
  function automatic int words_of(input int depth_bytes);
    return depth_bytes / WORD_BYTES;
  endfunction
endpackage

// File: rtl/instr_mem_bank.sv
// instr_mem_bank: word-wide storage, synchronous read port, byte-enable write port
module instr_mem_bank #(
  parameter int WORDS = 4096,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wbe
);
  logic [31:0] r_mem [WORDS];
  // read and write in the same edge: the read sees the pre-write word
  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
    for (int b = 0; b < 4; b++)
      if (i_we && i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: instruction memory with zero-fill init, 1-cycle fetch port and program-load port
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 16384,
  parameter int ADDR_W = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [3:0]        load_be,
  output logic              init_done
);
  localparam int WORDS = words_of(DEPTH_BYTES);
  localparam int AW = $clog2(WORDS);
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic r_valid, r_fault;
  logic w_init, w_accept, w_fetch_fault, w_re, w_load_ok, w_we, w_unused;
  logic [AW-1:0] w_waddr;
  logic [31:0] w_wdata, w_rdata;
  logic [3:0] w_wbe;

  assign w_init = r_state == INIT;
  assign init_done = r_state == RUN;
  assign fetch_ready = (r_state == RUN) & ~fetch_stall;
  assign w_accept = fetch_req & fetch_ready;
  assign w_fetch_fault = (fetch_addr[1:0] != 2'b00) | (fetch_addr >= ADDR_W'(DEPTH_BYTES));
  assign w_re = w_accept & ~w_fetch_fault;
  assign w_load_ok = load_en & (load_addr < ADDR_W'(DEPTH_BYTES));
  assign w_unused = ^load_addr[1:0];

  // state register and fill word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_init) r_cnt <= r_cnt + 1'b1;
    end
  end

  // next state and write-port mux: fill owns the port in INIT, the load port in RUN
  always_comb begin
    w_next = w_init ? (((INIT_ZERO == 0) || (r_cnt == AW'(WORDS - 1))) ? RUN : INIT) : RUN;
    w_we = ~rst & (w_init ? (INIT_ZERO != 0) : w_load_ok);
    w_waddr = w_init ? r_cnt : load_addr[AW+1:2];
    w_wdata = w_init ? NOP_WORD : load_data;
    w_wbe = w_init ? 4'hF : load_be;
  end

  // fetch result flags; a stall freezes them together with the bank read register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (!fetch_stall) begin
      r_valid <= w_accept;
      r_fault <= w_accept & w_fetch_fault;
    end
  end

  assign fetch_valid = r_valid;
  assign fetch_fault = r_fault;
  assign fetch_instr = (r_valid & ~r_fault) ? w_rdata : NOP_WORD;

  instr_mem_bank #(.WORDS(WORDS), .AW(AW)) u_bank (
    .clk     (clk),
    .i_re    (w_re),
    .i_raddr (fetch_addr[AW+1:2]),
    .o_rdata (w_rdata),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_wbe   (w_wbe)
  );
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed bench with a byte-array reference model for a small and a larger instance
module tb_instr_fetch_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fetch_req, fetch_stall, load_en;
  logic [31:0] fetch_addr, load_addr, load_data;
  logic [3:0] load_be;
  logic s_ready, s_valid, s_fault, s_done, b_ready, b_valid, b_fault, b_done;
  logic [31:0] s_instr, b_instr;

  instr_fetch_mem #(.DEPTH_BYTES(64), .ADDR_W(32), .INIT_ZERO(1)) u_s (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_ready(s_ready), .fetch_valid(s_valid), .fetch_instr(s_instr), .fetch_fault(s_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_be(load_be), .init_done(s_done));

  instr_fetch_mem #(.DEPTH_BYTES(1024), .ADDR_W(32), .INIT_ZERO(1)) u_b (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_ready(b_ready), .fetch_valid(b_valid), .fetch_instr(b_instr), .fetch_fault(b_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_be(load_be), .init_done(b_done));

  int total = 0, bad = 0;
  localparam int NW [2] = '{16, 256};
  logic [7:0] mm [2][1024];
  int edges [2] = '{0, 0};
  bit ev [2] = '{0, 0};
  bit ef [2] = '{0, 0};
  bit erst [2] = '{1, 1};
  logic [31:0] ei [2] = '{32'h0, 32'h0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic compare(input int k, input logic val, input logic flt, input logic [31:0] ins,
                         input logic rdy, input logic dn);
    bit run;
    string p;
    run = edges[k] >= NW[k];
    p = (k == 0) ? "small" : "big";
    chk({p, "_valid"}, 32'(val), 32'(ev[k]));
    chk({p, "_ready"}, 32'(rdy), 32'(run && !fetch_stall));
    chk({p, "_init_done"}, 32'(dn), 32'(run));
    if (ev[k] || erst[k]) begin
      chk({p, "_fault"}, 32'(flt), 32'(ef[k]));
      chk({p, "_instr"}, ins, ei[k]);
    end
  endtask

  task automatic step(input int k);
    bit run;
    int a, depth;
    depth = NW[k] * 4;
    if (rst) begin
      edges[k] = 0; ev[k] = 0; ef[k] = 0; ei[k] = 32'h0; erst[k] = 1;
      return;
    end
    erst[k] = 0;
    run = edges[k] >= NW[k];
    if (fetch_req && run && !fetch_stall) begin
      ev[k] = 1;
      ef[k] = (fetch_addr % 4 != 0) || (fetch_addr >= 32'(depth));
      ei[k] = 32'h0;
      a = int'(fetch_addr);
      if (!ef[k]) for (int j = 0; j < 4; j++) ei[k] = {ei[k][23:0], mm[k][a + j]};
    end else if (!fetch_stall) begin
      ev[k] = 0; ef[k] = 0; ei[k] = 32'h0;
    end
    if (run && load_en && load_addr < 32'(depth)) begin
      a = int'(load_addr & ~32'd3);
      for (int j = 0; j < 4; j++) if (load_be[3-j]) mm[k][a + j] = load_data[31-8*j -: 8];
    end
    if (!run && edges[k] + 1 == NW[k]) for (int i = 0; i < 1024; i++) mm[k][i] = 8'h0;
    if (!run) edges[k]++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare(0, s_valid, s_fault, s_instr, s_ready, s_done);
      compare(1, b_valid, b_fault, b_instr, b_ready, b_done);
      step(0);
      step(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    load_en = 1'b1; load_addr = a; load_data = d; load_be = be;
    cyc();
    load_en = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; fetch_req = 1'b0; fetch_stall = 1'b0; load_en = 1'b0;
    fetch_addr = '0; load_addr = '0; load_data = '0; load_be = '0;
    cyc();
    cyc();
    chk("rst_valid", 32'(b_valid), 32'h0);
    chk("rst_ready", 32'(b_ready), 32'h0);
    chk("rst_done", 32'(b_done), 32'h0);
    chk("rst_instr", b_instr, 32'h0);
    rst = 1'b0;
    n = 0;
    while (!s_done && n < 40) begin cyc(); n++; end
    chk("init_cycles_small", n, 16);
    while (!b_done && n < 400) begin cyc(); n++; end
    chk("init_cycles_big", n, 256);

    fetch(32'h10);
    chk("zero_valid", 32'(s_valid), 32'h1);
    chk("zero_instr", s_instr, 32'h0);
    chk("zero_fault", 32'(s_fault), 32'h0);

    load(32'd100, 32'h48080000, 4'hF);
    fetch(32'd100);
    chk("ld100_valid", 32'(b_valid), 32'h1);
    chk("ld100_instr", b_instr, 32'h48080000);
    chk("ld100_small_oor", 32'(s_fault), 32'h1);

    load(32'd104, 32'h24130005, 4'hF);
    load(32'd104, 32'h0000ABCD, 4'b0011);
    fetch(32'd104);
    chk("be_merge", b_instr, 32'h2413ABCD);

    fetch_req = 1'b1; fetch_addr = 32'h66;
    cyc();
    chk("misalign_fault", 32'(b_fault), 32'h1);
    chk("misalign_instr", b_instr, 32'h0);
    fetch_addr = 32'd64;
    cyc();
    chk("depth64_fault", 32'(s_fault), 32'h1);
    chk("depth64_big_ok", 32'(b_fault), 32'h0);
    fetch_addr = 32'd1024;
    cyc();
    chk("depth1024_fault", 32'(b_fault), 32'h1);
    chk("depth1024_instr", b_instr, 32'h0);
    fetch_req = 1'b0;
    cyc();
    chk("idle_valid", 32'(b_valid), 32'h0);

    fetch(32'd100);
    fetch_stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'd104;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", 32'(b_valid), 32'h1);
      chk("stall_instr", b_instr, 32'h48080000);
      chk("stall_ready", 32'(b_ready), 32'h0);
    end
    fetch_stall = 1'b0; fetch_req = 1'b0;
    cyc();
    chk("post_stall_valid", 32'(b_valid), 32'h0);

    load_en = 1'b1; load_addr = 32'd412; load_data = 32'hAC130064; load_be = 4'hF;
    fetch_req = 1'b1; fetch_addr = 32'd412;
    cyc();
    load_en = 1'b0; fetch_req = 1'b0;
    chk("rbw_old", b_instr, 32'h0);
    fetch(32'd412);
    chk("rbw_new", b_instr, 32'hAC130064);

    load(32'd418, 32'hDE000000, 4'b1000);
    fetch(32'd416);
    chk("ld_low_bits_ignored", b_instr, 32'hDE000000);
    load(32'd1024, 32'hFFFFFFFF, 4'hF);
    fetch(32'd0);
    chk("ld_oor_dropped", b_instr, 32'h0);

    for (int i = 0; i < 8; i++) load(32'(200 + 4 * i), 32'h01020304 * (i + 1), 4'(i + 9));
    fetch_req = 1'b1;
    for (int i = 0; i < 8; i++) begin fetch_addr = 32'(200 + 4 * i); cyc(); end
    fetch_req = 1'b0;
    cyc();

    fetch_req = 1'b1; fetch_addr = 32'd100;
    cyc();
    rst = 1'b1; fetch_req = 1'b0;
    cyc();
    chk("midrst_valid", 32'(b_valid), 32'h0);
    chk("midrst_done", 32'(b_done), 32'h0);
    rst = 1'b0;
    n = 0;
    while (!b_done && n < 400) begin cyc(); n++; end
    chk("reinit_cycles", n, 256);
    fetch(32'd100);
    chk("refill_cleared", b_instr, 32'h0);
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
